bcd_to_decimal_serial_decoder: RTL
==================================

BCD_TO_DECIMAL_SERIAL_DECODER -- requirements
Module: bcd_to_decimal_serial_decoder

Interface
REQ-001 The block SHALL have parameter NDIGITS, default 4, giving the number of BCD digits per input word (legal range 2..8).
REQ-002 The block SHALL have parameter IDXW, default 2, giving the digit-index width; it SHALL equal clog2(NDIGITS).
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: in_bcd holds a word to decode.
REQ-006 Port in_bcd, input, 4*NDIGITS bits: packed BCD word; digit 0 is bits [3:0].
REQ-007 Port in_ready, output, 1 bit: the block can accept a word.
REQ-008 Port out_valid, output, 1 bit: the out_* fields hold a decoded digit.
REQ-009 Port out_ready, input, 1 bit: the consumer accepts the current digit.
REQ-010 Port out_onehot, output, 10 bits: decimal one-hot code; bit n set means digit value n.
REQ-011 Port out_idx, output, IDXW bits: position of the current digit within the word.
REQ-012 Port out_last, output, 1 bit: the current digit is digit NDIGITS-1.
REQ-013 Port out_err, output, 1 bit: the current nibble is illegal BCD (value 10..15).
REQ-014 Port err_count, output, 8 bits: saturating count of illegal nibbles emitted.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and SEND; in_ready SHALL be 1 only in IDLE and out_valid SHALL be 1 only in SEND.
REQ-016 IDLE->SEND SHALL occur on the edge where in_valid&&in_ready; that edge SHALL capture in_bcd into an internal word register and set the digit index to 0.
REQ-017 Latency SHALL be one cycle: out_valid SHALL be 1 in the cycle immediately after the input handshake.
REQ-018 In SEND, the digit index SHALL increment by 1 on each edge where out_valid&&out_ready, unless out_last=1.
REQ-019 In SEND, out_valid&&out_ready with out_last=1 SHALL return the FSM to IDLE; in_ready SHALL be 1 in the next cycle, with no extra bubble.
REQ-020 While out_valid=1 and out_ready=0, out_onehot, out_idx, out_last and out_err SHALL hold stable.
REQ-021 A captured word SHALL not change while in SEND; in_bcd and in_valid SHALL be ignored outside IDLE.
REQ-022 For a nibble value v of 0..9: out_onehot SHALL be 1<<v and out_err SHALL be 0.
REQ-023 For a nibble value of 10..15: out_onehot SHALL be 10'h000 and out_err SHALL be 1; the digit SHALL still be emitted and SHALL consume one handshake.
REQ-024 err_count SHALL increment by 1 on each out handshake with out_err=1 and SHALL saturate at 8'hFF without wrapping.
REQ-025 Words SHALL be emitted strictly in acceptance order, and every digit of every accepted word SHALL be emitted in order 0..NDIGITS-1.
REQ-026 out_onehot, out_idx, out_last and out_err SHALL be 0 whenever out_valid=0.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, in_ready=1 and out_valid=0, and set out_onehot, out_idx, out_last, out_err and err_count to 0.
REQ-028 Reset asserted mid-word SHALL discard the remaining digits; after release, the first accepted word SHALL start at index 0.
REQ-029 After rst_n deasserts, the first handshake SHALL be possible at the first rising edge.

Verification
REQ-030 With out_ready held at 1, input in_bcd=16'h4921 -> out_onehot SHALL read 10'h002, 10'h004, 10'h200, 10'h010 on 4 consecutive cycles, with out_idx 0..3, out_last=1 only on idx 3, and in_ready=1 in the following cycle.
REQ-031 Input 16'h0F0A -> out_err sequence SHALL be 1,0,1,0, out_onehot sequence SHALL be 0,10'h001,0,10'h001, and err_count SHALL be 2.
REQ-032 Word 16'h8765 with out_ready toggling 0,1 every cycle -> each digit SHALL be held stable for 2 cycles, and the 8 cycles SHALL produce digits 5,6,7,8.
REQ-033 in_valid held at 1 during SEND with a different in_bcd -> the output SHALL be unaffected, and the second word SHALL be accepted only once the FSM is back in IDLE.
REQ-034 Reset pulsed after 2 digits of 16'h3210 -> out_valid SHALL drop immediately, and the next word 16'h9999 SHALL emit 10'h200 x4 starting at idx 0.
REQ-035 Feeding 64 words of 16'hFFFF (256 errors) -> err_count SHALL hold at 8'hFF.

Source files
------------

// File: rtl/bcd_to_decimal_serial_decoder.sv
// Serialises a packed BCD word into one decimal one-hot digit per handshake,
// low digit first, flagging illegal nibbles and counting them (saturating).
module bcd_to_decimal_serial_decoder #(
  parameter int NDIGITS = 4,
  parameter int IDXW    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [4*NDIGITS-1:0] in_bcd,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [9:0]           out_onehot,
  output logic [IDXW-1:0]      out_idx,
  output logic                 out_last,
  output logic                 out_err,
  output logic [7:0]           err_count
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                 state_q;
  logic [4*NDIGITS-1:0]   word_q;
  logic [IDXW-1:0]        next_idx;
  logic [3:0]             next_nib;
  logic [3:0]             cap_nib;

  function automatic logic [9:0] bcd_onehot(input logic [3:0] v);
    logic [9:0] oh;
    oh = '0;
    if (v < 4'd10) oh[v] = 1'b1;
    return oh;
  endfunction

  function automatic logic bcd_illegal(input logic [3:0] v);
    return v > 4'd9;
  endfunction

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StSend);
  assign cap_nib   = in_bcd[3:0];

  // Nibble that becomes current after the next output handshake.
  always_comb begin
    next_idx = out_idx + IDXW'(1);
    next_nib = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (next_idx == IDXW'(i)) next_nib = word_q[4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      word_q     <= '0;
      out_onehot <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      out_err    <= 1'b0;
      err_count  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q    <= StSend;
            word_q     <= in_bcd;
            out_onehot <= bcd_onehot(cap_nib);
            out_idx    <= '0;
            out_last   <= 1'b0;
            out_err    <= bcd_illegal(cap_nib);
          end
        end
        StSend: begin
          if (out_ready) begin
            if (out_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
            if (out_last) begin
              state_q    <= StIdle;
              out_onehot <= '0;
              out_idx    <= '0;
              out_last   <= 1'b0;
              out_err    <= 1'b0;
            end else begin
              out_onehot <= bcd_onehot(next_nib);
              out_idx    <= next_idx;
              out_last   <= (next_idx == IDXW'(NDIGITS - 1));
              out_err    <= bcd_illegal(next_nib);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
